// File: rtl/hazard_ctrl_seq_pkg.sv
// hazard_ctrl_seq_pkg
// Shared definitions for the ID-stage hazard controller:
//   - state_t      : FSM encoding (RUN=0, MEM_WAIT=1, TRAP_HOLD=2), also
//                    the value presented on state_o
//   - REG_ZERO     : architectural zero register, never a real dependency
package hazard_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_TRAP_HOLD = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_seq_match.sv
// hazard_match
// Combinational N_SRC-way load-use comparator. Raises o_hit when the
// instruction in EX is a load whose (non-zero) destination matches any
// source operand that the ID-stage instruction actually uses.
// Ports:
//   i_rs        packed source register numbers, source i at [i*REG_ADDR_W +: REG_ADDR_W]
//   i_rs_valid  per-source "operand used" flags
//   i_rd        destination register of the instruction in EX
//   i_memread   instruction in EX is a load
//   o_hit       load-use hazard present
module hazard_match
  import hazard_ctrl_seq_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int N_SRC      = 3
) (
  input  logic [N_SRC*REG_ADDR_W-1:0] i_rs,
  input  logic [N_SRC-1:0]            i_rs_valid,
  input  logic [REG_ADDR_W-1:0]       i_rd,
  input  logic                        i_memread,
  output logic                        o_hit
);

  logic [N_SRC-1:0] w_src_hit;

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign w_src_hit[gi] = i_rs_valid[gi] &&
                             (i_rs[gi*REG_ADDR_W +: REG_ADDR_W] == i_rd);
    end
  endgenerate

  // Writes to x0 are discarded, so a load targeting it creates no dependency.
  assign o_hit = i_memread &&
                 (i_rd != REG_ADDR_W'(REG_ZERO)) &&
                 (|w_src_hit);

endmodule

// File: rtl/hazard_ctrl_seq.sv
// hazard_ctrl_seq
// ID-stage stall/bubble controller for the 5-stage core with registered
// memory-wait tracking (with timeout), syscall hold while branches are in
// flight, and a saturating stall-cycle counter.
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   ifid_rs, ifid_rs_valid         ID source operands and their use flags
//   ifid_memread                   load in ID
//   idex_rd, idex_memread,
//   idex_memwrite                  destination / load / store of instruction in EX
//   mem_ready                      data memory ready
//   jump, trap_in_id               jump / trap instruction in ID
//   idex_branch, exmem_branch      branches in EX / MEM
//   syscall, int_trap,
//   branch_taken, flush_pipeline   trap and redirect controls
//   bubble_*                       insert NOP into IF/ID, ID/EX, EX/MEM, MEM/WB
//   write_*                        pipeline register and PC write enables
//   trap_waiting                   syscall may be taken this cycle
//   mem_timeout                    one-cycle pulse on memory-wait timeout
//   stall_count                    saturating count of cycles with write_pc=0
//   state_o                        current FSM state
module hazard_ctrl_seq
  import hazard_ctrl_seq_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int N_SRC       = 3,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_SRC*REG_ADDR_W-1:0] ifid_rs,
  input  logic [N_SRC-1:0]            ifid_rs_valid,
  input  logic                        ifid_memread,
  input  logic [REG_ADDR_W-1:0]       idex_rd,
  input  logic                        idex_memread,
  input  logic                        idex_memwrite,
  input  logic                        mem_ready,
  input  logic                        jump,
  input  logic                        trap_in_id,
  input  logic                        idex_branch,
  input  logic                        exmem_branch,
  input  logic                        syscall,
  input  logic                        int_trap,
  input  logic                        branch_taken,
  input  logic                        flush_pipeline,
  output logic                        bubble_ifid,
  output logic                        bubble_idex,
  output logic                        bubble_exmem,
  output logic                        bubble_memwb,
  output logic                        write_ifid,
  output logic                        write_idex,
  output logic                        write_exmem,
  output logic                        write_memwb,
  output logic                        write_pc,
  output logic                        trap_waiting,
  output logic                        mem_timeout,
  output logic [CNT_W-1:0]            stall_count,
  output logic [1:0]                  state_o
);

  // The wait counter runs 0..MEM_TIMEOUT. It counts consecutive mem_ready=0
  // cycles; reaching WAIT_LAST fires the timeout and the step to WAIT_DONE
  // marks "already fired" so the pulse cannot repeat within one wait episode.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_DONE = WAIT_W'(MEM_TIMEOUT);

  state_t            r_state;
  state_t            w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic              r_mem_timeout;
  logic              w_mem_timeout_next;
  logic [CNT_W-1:0]  r_stall_count;

  logic w_force_run;
  logic w_trap_hold_cond;
  logic w_store_load;
  logic w_load_use;
  logic w_waiting;

  hazard_match #(
    .REG_ADDR_W (REG_ADDR_W),
    .N_SRC      (N_SRC)
  ) u_hazard_match (
    .i_rs       (ifid_rs),
    .i_rs_valid (ifid_rs_valid),
    .i_rd       (idex_rd),
    .i_memread  (idex_memread),
    .o_hit      (w_load_use)
  );

  assign w_force_run      = int_trap | branch_taken;
  assign w_trap_hold_cond = (idex_branch | exmem_branch) & syscall;
  assign w_store_load     = ifid_memread & idex_memwrite;
  // A trap or taken branch ends any memory wait, even with mem_ready low.
  assign w_waiting        = !mem_ready && !w_force_run;

  // Pipeline controls: priority chain, then flush overlay.
  always_comb begin
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    bubble_memwb = 1'b0;
    write_ifid   = 1'b1;
    write_idex   = 1'b1;
    write_exmem  = 1'b1;
    write_memwb  = 1'b1;
    write_pc     = 1'b1;
    trap_waiting = syscall;

    if (reset) begin
      bubble_ifid  = 1'b1;
      bubble_idex  = 1'b1;
      bubble_exmem = 1'b1;
      bubble_memwb = 1'b1;
      trap_waiting = 1'b0;
    end else begin
      if (int_trap) begin
        bubble_ifid  = 1'b1;
        bubble_idex  = 1'b1;
        bubble_exmem = 1'b1;
        bubble_memwb = 1'b1;
        write_pc     = 1'b1;
      end else if (branch_taken) begin
        bubble_ifid  = 1'b1;
        bubble_idex  = 1'b1;
        bubble_exmem = 1'b1;
        write_pc     = 1'b1;
      end else if (!mem_ready) begin
        write_ifid   = 1'b0;
        write_idex   = 1'b0;
        write_exmem  = 1'b0;
        write_memwb  = 1'b0;
        write_pc     = 1'b0;
        trap_waiting = 1'b0;
      end else if (w_trap_hold_cond) begin
        // PC keeps advancing here; only the ID instruction is held back.
        bubble_idex  = 1'b1;
        write_ifid   = 1'b0;
        trap_waiting = 1'b0;
      end else if (w_store_load || w_load_use) begin
        bubble_idex  = 1'b1;
        write_ifid   = 1'b0;
        write_pc     = 1'b0;
        trap_waiting = 1'b0;
      end else if (jump || trap_in_id) begin
        bubble_ifid  = 1'b1;
      end

      if (flush_pipeline) begin
        bubble_ifid = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    if (w_force_run) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!mem_ready) begin
            w_state_next = ST_MEM_WAIT;
          end else if (w_trap_hold_cond) begin
            w_state_next = ST_TRAP_HOLD;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            w_state_next = ST_RUN;
          end
        end
        ST_TRAP_HOLD: begin
          if (!mem_ready) begin
            w_state_next = ST_MEM_WAIT;
          end else if (!w_trap_hold_cond) begin
            w_state_next = ST_RUN;
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  // Memory-wait counter and timeout pulse.
  always_comb begin
    w_wait_cnt_next    = '0;
    w_mem_timeout_next = 1'b0;
    if (w_waiting) begin
      w_wait_cnt_next    = (r_wait_cnt != WAIT_DONE) ? r_wait_cnt + WAIT_W'(1)
                                                     : r_wait_cnt;
      w_mem_timeout_next = (r_wait_cnt == WAIT_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_mem_timeout <= w_mem_timeout_next;
      if (!write_pc && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign state_o     = r_state;
  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;

endmodule
